// File: rtl/ram32_master.sv
// ram32_master
//   Initiator for one 32x32 single-port byte-enable RAM macro. Accepts
//   byte-addressed byte/halfword/word requests on a valid/ready interface and
//   turns each into one macro cycle, or two when the access crosses a word
//   boundary (the second word index wraps modulo WORDS). Every accepted request
//   produces exactly one rsp_valid pulse carrying right-justified,
//   zero-extended read data (0 for writes).
//
//   Build option: RAM32_MASTER_ALIGN_CHECK_EN
//     defined   - boundary-crossing requests are rejected without touching the
//                 macro; they answer with rsp_err=1 and rsp_rdata=0.
//     undefined - boundary-crossing requests are split; rsp_err is tied to 0.
//
//   Ports
//     CLK        clock, shared with the macro
//     RST        synchronous reset, active-high
//     req_valid  request present
//     req_ready  request accepted when req_valid & req_ready at rising CLK
//     req_we     1 = write, 0 = read
//     req_size   0 = byte, 1 = halfword, 2/3 = word
//     req_addr   byte address, any alignment
//     req_wdata  write data, right-justified
//     rsp_valid  one-cycle pulse per accepted request
//     rsp_rdata  read data, right-justified and zero-extended; 0 for writes
//     rsp_err    misalignment error (option only, otherwise constant 0)
//     ram_en     macro EN0 (registered)
//     ram_we     macro WE0 byte enables (registered)
//     ram_a      macro A0 word address (registered)
//     ram_di     macro Di0 write data (registered)
//     ram_do     macro Do0, valid the cycle after ram_en
module ram32_master #(
  parameter int AW    = 7,
  parameter int WORDS = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-3:0] ram_a,
  output logic [31:0]   ram_di,
  input  logic [31:0]   ram_do
);

  localparam int            IW        = AW - 2;
  localparam logic [IW-1:0] LAST_WORD = IW'(WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC1 = 2'd1;
  localparam logic [1:0] S_ACC2 = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Byte lanes covered by an access of the given size, starting at lane 0.
  function automatic logic [3:0] lane_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  logic [1:0]    state;

  // Request context captured at accept time.
  logic          we_q;
  logic [1:0]    size_q;
  logic [1:0]    off_q;
  logic [IW-1:0] word_q;
  logic          span_q;
  logic [3:0]    we_hi_q;
  logic [31:0]   di_hi_q;
  logic [31:0]   word0_q;
`ifdef RAM32_MASTER_ALIGN_CHECK_EN
  logic          err_q;
`endif

  // Accept-side decode. The lane mask and write data are shifted into an
  // 8-lane / 64-bit window spanning two words: the low half is the first macro
  // access, the high half is whatever spills into the next word.
  logic          accept;
  logic          issue_first;
  logic [1:0]    acc_off;
  logic [7:0]    acc_lanes;
  logic [63:0]   acc_data;
  logic          acc_span;

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign acc_off   = req_addr[1:0];
  assign acc_lanes = {4'b0000, lane_mask(req_size)} << acc_off;
  assign acc_data  = {32'h0, req_wdata} << {acc_off, 3'b000};
  assign acc_span  = ({1'b0, acc_off} + byte_count(req_size)) > 3'd4;

`ifdef RAM32_MASTER_ALIGN_CHECK_EN
  assign issue_first = accept && !acc_span;
`else
  assign issue_first = accept;
`endif

  logic [IW-1:0] next_word;
  assign next_word = (word_q == LAST_WORD) ? '0 : word_q + IW'(1);

  // Read assembly: the two words form a 64-bit pair (first word low), shifted
  // down by the byte offset and masked to the access size. An unsplit access
  // only has the live ram_do word, with zeros above it.
  logic [31:0] rd_lo;
  logic [31:0] rd_hi;
  logic [63:0] rd_shift;
  logic [31:0] rd_word;
  logic        unused_rd_upper;

  assign rd_lo    = span_q ? word0_q : ram_do;
  assign rd_hi    = span_q ? ram_do  : 32'h0;
  assign rd_shift = {rd_hi, rd_lo} >> {off_q, 3'b000};
  assign rd_word  = rd_shift[31:0] & lane_bits(lane_mask(size_q));
  // The upper half of the shifted pair never reaches the response.
  assign unused_rd_upper = ^rd_shift[63:32];

  // NOTE: every register in a clocked block is assigned with <= so all of them
  // update together from the values sampled at the edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      ram_en    <= 1'b0;
      ram_we    <= 4'b0000;
      ram_a     <= '0;
      ram_di    <= 32'h0;
`ifdef RAM32_MASTER_ALIGN_CHECK_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
`ifdef RAM32_MASTER_ALIGN_CHECK_EN
      rsp_err   <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          ram_en <= 1'b0;
          ram_we <= 4'b0000;
          // A rejected request skips the macro and answers straight from DONE.
          if (accept) state <= issue_first ? S_ACC1 : S_DONE;
          if (issue_first) begin
            ram_en <= 1'b1;
            ram_a  <= req_addr[AW-1:2];
            ram_we <= req_we ? acc_lanes[3:0] : 4'b0000;
            ram_di <= acc_data[31:0];
          end
        end
        S_ACC1: begin
          if (span_q) begin
            state  <= S_ACC2;
            ram_en <= 1'b1;
            ram_a  <= next_word;
            ram_we <= we_q ? we_hi_q : 4'b0000;
            ram_di <= di_hi_q;
          end else begin
            state  <= S_DONE;
            ram_en <= 1'b0;
            ram_we <= 4'b0000;
          end
        end
        S_ACC2: begin
          state  <= S_DONE;
          ram_en <= 1'b0;
          ram_we <= 4'b0000;
        end
        S_DONE: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b1;
`ifdef RAM32_MASTER_ALIGN_CHECK_EN
          rsp_err   <= err_q;
          rsp_rdata <= (we_q || err_q) ? 32'h0 : rd_word;
`else
          rsp_rdata <= we_q ? 32'h0 : rd_word;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: request context needs no reset; it is always loaded on accept before
  // the FSM leaves IDLE, so its power-up value is never observed.
  always_ff @(posedge CLK) begin
    if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      off_q   <= acc_off;
      word_q  <= req_addr[AW-1:2];
      span_q  <= acc_span;
      we_hi_q <= req_we ? acc_lanes[7:4] : 4'b0000;
      di_hi_q <= acc_data[63:32];
`ifdef RAM32_MASTER_ALIGN_CHECK_EN
      err_q   <= acc_span;
`endif
    end
    // In ACC2 the macro presents the first word of a split access.
    if (state == S_ACC2) word0_q <= ram_do;
  end

`ifndef RAM32_MASTER_ALIGN_CHECK_EN
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram32_master.sv
// tb_ram32_master
//   Self-checking bench for ram32_master. A behavioural 32x32 byte-enable
//   macro is attached to the ram_* port. Each request is expanded byte by byte
//   against a 128-byte shadow memory; the expected macro cycles and the
//   expected response (data, error flag, arrival cycle) are queued when the
//   request is driven and compared when the DUT produces them.
module tb_ram32_master;

`ifdef RAM32_MASTER_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        CLK;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [4:0]  ram_a;
  logic [31:0] ram_di;
  logic [31:0] ram_do;

  ram32_master dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_a     (ram_a),
    .ram_di    (ram_di),
    .ram_do    (ram_do)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural macro: registered read port, zero after an idle cycle.
  logic [31:0] mem [32] = '{default: 32'h0};
  logic [31:0] mem_nw;
  always @(posedge CLK) begin
    if (ram_en === 1'b1) begin
      ram_do <= mem[ram_a];
      mem_nw = mem[ram_a];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem_nw[8*b +: 8] = ram_di[8*b +: 8];
      mem[ram_a] <= mem_nw;
    end else begin
      ram_do <= 32'h0;
    end
  end

  typedef struct {
    logic [4:0]  a;
    logic [3:0]  we;
    logic [3:0]  mask;
    logic [31:0] di;
  } acc_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  acc_t       acc_q[$];
  rsp_t       rsp_q[$];
  logic [7:0] shadow [128];

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard side: compare macro cycles and responses as they appear.
  always @(negedge CLK) begin
    acc_t        ea;
    rsp_t        er;
    logic [31:0] dmask;
    if (ram_en === 1'b1) begin
      if (acc_q.size() == 0) begin
        n_checks++;
        $display("FAIL mac_unexpected a=%0d we=%b di=%h (no macro cycle expected)", ram_a, ram_we, ram_di);
      end else begin
        ea = acc_q.pop_front();
        n_checks++;
        if (ram_a !== ea.a) $display("FAIL mac_addr got=%0d exp=%0d", ram_a, ea.a);
        else n_pass++;
        n_checks++;
        if (ram_we !== ea.we) $display("FAIL mac_we a=%0d got=%b exp=%b", ea.a, ram_we, ea.we);
        else n_pass++;
        if (ea.mask != 4'b0000) begin
          dmask = {{8{ea.mask[3]}}, {8{ea.mask[2]}}, {8{ea.mask[1]}}, {8{ea.mask[0]}}};
          n_checks++;
          if ((ram_di & dmask) !== ea.di)
            $display("FAIL mac_di a=%0d got=%h exp=%h (lanes %b)", ea.a, ram_di & dmask, ea.di, ea.mask);
          else n_pass++;
        end
      end
    end else begin
      n_checks++;
      if (ram_we !== 4'b0000) $display("FAIL idle_we got=%b exp=0000", ram_we);
      else n_pass++;
    end

    if (rsp_valid === 1'b1) begin
      if (rsp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rsp_unexpected rdata=%h err=%b (no response expected)", rsp_rdata, rsp_err);
      end else begin
        er = rsp_q.pop_front();
        n_checks++;
        if (rsp_rdata !== er.rdata) $display("FAIL rsp_rdata got=%h exp=%h", rsp_rdata, er.rdata);
        else n_pass++;
        n_checks++;
        if (rsp_err !== er.err) $display("FAIL rsp_err got=%b exp=%b", rsp_err, er.err);
        else n_pass++;
        n_checks++;
        if (cyc !== er.cyc) $display("FAIL rsp_latency arrived=%0d exp=%0d", cyc, er.cyc);
        else n_pass++;
      end
    end
  end

  // Drive one request, queue its expectations, return at the negedge after
  // the accept edge. With abort set, RST is raised right after accept and the
  // task returns (RST still high) at the negedge after the reset edge.
  task automatic send(input bit we, input logic [1:0] size, input logic [6:0] addr,
                      input logic [31:0] wdata, input bit abort);
    int         nb;
    int         waited;
    bit         span;
    bit         err;
    logic [6:0] ba;
    acc_t       a0;
    acc_t       a1;
    rsp_t       r;
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    waited    = 0;
    while (req_ready !== 1'b1 && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    if (req_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL accept_timeout addr=%h waited=%0d cycles", addr, waited);
      req_valid = 1'b0;
      return;
    end

    nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    span = (int'(addr[1:0]) + nb) > 4;
    err  = ALIGN && span;
    a0.a = addr[6:2];
    a1.a = addr[6:2] + 5'd1;
    a0.mask = 4'b0000; a0.di = 32'h0;
    a1.mask = 4'b0000; a1.di = 32'h0;
    r.rdata = 32'h0;
    r.err   = err;
    r.cyc   = cyc + (err ? 2 : span ? 4 : 3);
    if (!err) begin
      for (int i = 0; i < nb; i++) begin
        ba = addr + 7'(i);
        if (ba[6:2] == addr[6:2]) begin
          a0.mask[ba[1:0]] = 1'b1;
          a0.di[8*ba[1:0] +: 8] = wdata[8*i +: 8];
        end else begin
          a1.mask[ba[1:0]] = 1'b1;
          a1.di[8*ba[1:0] +: 8] = wdata[8*i +: 8];
        end
        if (we) begin
          if (!abort || ba[6:2] == addr[6:2]) shadow[ba] = wdata[8*i +: 8];
        end else begin
          r.rdata[8*i +: 8] = shadow[ba];
        end
      end
    end
    a0.we = we ? a0.mask : 4'b0000;
    a1.we = we ? a1.mask : 4'b0000;
    if (!we) begin
      a0.mask = 4'b0000;
      a1.mask = 4'b0000;
    end
    if (!err) begin
      acc_q.push_back(a0);
      if (span && !abort) acc_q.push_back(a1);
    end
    if (!abort) rsp_q.push_back(r);

    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    if (abort) begin
      RST = 1'b1;
      @(negedge CLK);
    end
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    while ((acc_q.size() != 0 || rsp_q.size() != 0) && n < 40) begin
      @(negedge CLK);
      n++;
    end
    ok = (acc_q.size() == 0 && rsp_q.size() == 0);
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'd0;
    req_addr = 7'h00;
    req_wdata = 32'h0;
    for (int i = 0; i < 128; i++) shadow[i] = 8'h00;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({req_ready, rsp_valid, rsp_err, ram_en, ram_we} !== 8'b1000_0000)
      $display("FAIL reset_ctrl ready/rsp_valid/err/en/we got=%b exp=10000000",
               {req_ready, rsp_valid, rsp_err, ram_en, ram_we});
    else n_pass++;
    n_checks++;
    if (rsp_rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=00000000", rsp_rdata);
    else n_pass++;
    n_checks++;
    if (ram_a !== 5'd0) $display("FAIL reset_ram_a got=%0d exp=0", ram_a);
    else n_pass++;
    n_checks++;
    if (ram_di !== 32'h0) $display("FAIL reset_ram_di got=%h exp=00000000", ram_di);
    else n_pass++;
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_aligned();
    bit ok;
    send(1'b1, 2'd2, 7'h08, 32'hDEADBEEF, 1'b0);
    send(1'b0, 2'd0, 7'h0A, 32'h0, 1'b0);
    send(1'b0, 2'd1, 7'h09, 32'h0, 1'b0);
    send(1'b1, 2'd0, 7'h11, 32'hFFFF_FF5A, 1'b0);
    send(1'b1, 2'd1, 7'h12, 32'hAAAA_9C3E, 1'b0);
    send(1'b0, 2'd3, 7'h10, 32'h0, 1'b0);
    send(1'b0, 2'd2, 7'h08, 32'h0, 1'b0);
    drain(ok);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL aligned_drain outstanding acc=%0d rsp=%0d", acc_q.size(), rsp_q.size());
    else n_pass++;
  endtask

  task automatic test_split();
    bit ok;
    send(1'b1, 2'd1, 7'h0B, 32'h0000_1234, 1'b0);
    send(1'b0, 2'd1, 7'h0B, 32'h0, 1'b0);
    send(1'b1, 2'd2, 7'h0D, 32'h0F1E_2D3C, 1'b0);
    send(1'b0, 2'd2, 7'h0D, 32'h0, 1'b0);
    send(1'b0, 2'd0, 7'h0E, 32'h0, 1'b0);
    send(1'b0, 2'd3, 7'h0B, 32'h0, 1'b0);
    send(1'b0, 2'd2, 7'h01, 32'h0, 1'b0);
    send(1'b0, 2'd1, 7'h0C, 32'h0, 1'b0);
    drain(ok);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL split_drain outstanding acc=%0d rsp=%0d", acc_q.size(), rsp_q.size());
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok;
    send(1'b1, 2'd2, 7'h7E, 32'hA1B2_C3D4, 1'b0);
    send(1'b0, 2'd2, 7'h7E, 32'h0, 1'b0);
    send(1'b1, 2'd1, 7'h7F, 32'h0000_BEEF, 1'b0);
    send(1'b0, 2'd1, 7'h7F, 32'h0, 1'b0);
    send(1'b0, 2'd0, 7'h00, 32'h0, 1'b0);
    send(1'b0, 2'd2, 7'h7C, 32'h0, 1'b0);
    drain(ok);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL wrap_drain outstanding acc=%0d rsp=%0d", acc_q.size(), rsp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    bit ok;
    send(1'b1, 2'd2, 7'h22, 32'h5566_7788, 1'b1);
    n_checks++;
    if ({ram_en, req_ready, rsp_valid} !== 3'b010)
      $display("FAIL abort_state en/ready/rsp_valid got=%b exp=010", {ram_en, req_ready, rsp_valid});
    else n_pass++;
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    send(1'b0, 2'd2, 7'h20, 32'h0, 1'b0);
    send(1'b0, 2'd2, 7'h24, 32'h0, 1'b0);
    drain(ok);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL abort_drain outstanding acc=%0d rsp=%0d", acc_q.size(), rsp_q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int i = 0; i < 40; i++)
      send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)),
           $urandom, 1'b0);
    drain(ok);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL b2b_drain outstanding acc=%0d rsp=%0d", acc_q.size(), rsp_q.size());
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_aligned();
    test_split();
    test_wrap();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
